uart_alu_framer: RTL and testbench



---
 rtl/uart_alu_framer.sv | 159 +++++++++++++++
 tb/tb_uart_alu_framer.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_framer.sv
// Byte-serial ALU: collects operand A, operand B and an opcode over a UART byte
// stream, computes the result and sends it back LSB first (or 8'hEE on a bad opcode).
module uart_alu_framer #(
  parameter int NB_DATA     = 16,
  parameter int NB_CODE     = 6,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx_done,
  input  logic [7:0]         i_rx_data,
  input  logic               i_tx_done,
  output logic               o_tx_start,
  output logic [7:0]         o_tx_data,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_result_valid,
  output logic               o_error,
  output logic               o_timeout,
  output logic               o_overrun,
  output logic [2:0]         o_dbg_state
);

  localparam int NBY = NB_DATA / 8;
  localparam int IW  = (NBY > 1) ? $clog2(NBY) : 1;
  localparam int TW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  localparam logic [NB_CODE-1:0] OP_ADD = NB_CODE'(6'b100000);
  localparam logic [NB_CODE-1:0] OP_SUB = NB_CODE'(6'b100010);
  localparam logic [NB_CODE-1:0] OP_AND = NB_CODE'(6'b100100);
  localparam logic [NB_CODE-1:0] OP_OR  = NB_CODE'(6'b100101);
  localparam logic [NB_CODE-1:0] OP_XOR = NB_CODE'(6'b100110);
  localparam logic [NB_CODE-1:0] OP_NOR = NB_CODE'(6'b100111);
  localparam logic [NB_CODE-1:0] OP_SRA = NB_CODE'(6'b000011);
  localparam logic [NB_CODE-1:0] OP_SRL = NB_CODE'(6'b000010);

  typedef enum logic [2:0] {RX_A, RX_B, RX_OP, EXEC, TX_LOAD, TX_WAIT} state_t;

  state_t             r_state, w_next;
  logic [IW-1:0]      r_idx, r_tx_idx;
  logic [TW-1:0]      r_to_cnt;
  logic [NB_DATA-1:0] r_a, r_b;
  logic [NB_CODE-1:0] r_op;
  logic               w_partial, w_to_hit, w_rx_acc, w_busy, w_last_byte, w_tx_last, w_op_ok;
  logic [7:0]         w_tx_byte;

  function automatic logic op_valid(input logic [NB_CODE-1:0] op);
    op_valid = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL};
  endfunction

  // Shift amounts of NB_DATA or more saturate explicitly rather than relying on operator semantics.
  function automatic logic [NB_DATA-1:0] alu(input logic [NB_DATA-1:0] a, input logic [NB_DATA-1:0] b,
                                             input logic [NB_CODE-1:0] op);
    logic big;
    big = (b >= NB_DATA'(NB_DATA));
    alu = '0;
    case (op)
      OP_ADD:  alu = a + b;
      OP_SUB:  alu = a - b;
      OP_AND:  alu = a & b;
      OP_OR:   alu = a | b;
      OP_XOR:  alu = a ^ b;
      OP_NOR:  alu = ~(a | b);
      OP_SRA:  alu = big ? {NB_DATA{a[NB_DATA-1]}} : $unsigned($signed(a) >>> b);
      OP_SRL:  alu = big ? '0 : (a >> b);
      default: alu = '0;
    endcase
  endfunction

  assign o_dbg_state = r_state;

  always_comb begin
    w_partial   = ((r_state == RX_A) && (r_idx != '0)) || (r_state == RX_B) || (r_state == RX_OP);
    w_to_hit    = (TIMEOUT_CYC != 0) && w_partial && (r_to_cnt == TW'(TIMEOUT_CYC - 1));
    w_busy      = (r_state == EXEC) || (r_state == TX_LOAD) || (r_state == TX_WAIT);
    w_rx_acc    = i_rx_done && !w_to_hit && !w_busy;
    w_last_byte = (r_idx == IW'(NBY - 1));
    w_op_ok     = op_valid(r_op);
    w_tx_last   = w_op_ok ? (r_tx_idx == IW'(NBY - 1)) : 1'b1;
    w_tx_byte   = w_op_ok ? o_result[8*r_tx_idx +: 8] : 8'hEE;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= RX_A;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_to_hit) begin
      w_next = RX_A;
    end else begin
      case (r_state)
        RX_A:    if (w_rx_acc && w_last_byte) w_next = RX_B;
        RX_B:    if (w_rx_acc && w_last_byte) w_next = RX_OP;
        RX_OP:   if (w_rx_acc) w_next = EXEC;
        EXEC:    w_next = TX_LOAD;
        TX_LOAD: w_next = TX_WAIT;
        TX_WAIT: if (i_tx_done) w_next = w_tx_last ? RX_A : TX_LOAD;
        default: w_next = RX_A;
      endcase
    end
  end

  // The result is registered on the opcode strobe so it is already visible during the EXEC cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_idx          <= '0;
      r_tx_idx       <= '0;
      r_to_cnt       <= '0;
      r_a            <= '0;
      r_b            <= '0;
      r_op           <= '0;
      o_result       <= '0;
      o_tx_data      <= '0;
      o_tx_start     <= 1'b0;
      o_result_valid <= 1'b0;
      o_error        <= 1'b0;
      o_timeout      <= 1'b0;
      o_overrun      <= 1'b0;
    end else begin
      o_tx_start     <= 1'b0;
      o_result_valid <= 1'b0;
      o_error        <= 1'b0;
      o_timeout      <= w_to_hit;
      o_overrun      <= i_rx_done && w_busy;
      r_to_cnt       <= (w_to_hit || w_rx_acc || !w_partial) ? '0 : r_to_cnt + TW'(1);
      if (w_to_hit) begin
        r_idx <= '0;
        r_a   <= '0;
        r_b   <= '0;
      end else begin
        case (r_state)
          RX_A: if (w_rx_acc) begin
            r_a[8*r_idx +: 8] <= i_rx_data;
            r_idx             <= w_last_byte ? '0 : r_idx + IW'(1);
          end
          RX_B: if (w_rx_acc) begin
            r_b[8*r_idx +: 8] <= i_rx_data;
            r_idx             <= w_last_byte ? '0 : r_idx + IW'(1);
          end
          RX_OP: if (w_rx_acc) begin
            r_op           <= i_rx_data[NB_CODE-1:0];
            o_result       <= alu(r_a, r_b, i_rx_data[NB_CODE-1:0]);
            o_result_valid <= 1'b1;
            o_error        <= !op_valid(i_rx_data[NB_CODE-1:0]);
            r_tx_idx       <= '0;
          end
          TX_LOAD: begin
            o_tx_data  <= w_tx_byte;
            o_tx_start <= 1'b1;
          end
          TX_WAIT: if (i_tx_done) r_tx_idx <= w_tx_last ? '0 : r_tx_idx + IW'(1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_alu_framer.sv
// Randomised bench for uart_alu_framer: a behavioural ALU model fills a TX scoreboard,
// and each scenario task checks latency, result, error, timeout, overrun and reset behaviour.
module tb_uart_alu_framer;

  localparam int NB_DATA     = 16;
  localparam int NB_CODE     = 6;
  localparam int TIMEOUT_CYC = 50;

  logic               i_clk = 1'b0;
  logic               i_reset = 1'b1;
  logic               i_rx_done = 1'b0;
  logic [7:0]         i_rx_data = 8'h00;
  logic               i_tx_done = 1'b0;
  logic               o_tx_start;
  logic [7:0]         o_tx_data;
  logic [NB_DATA-1:0] o_result;
  logic               o_result_valid, o_error, o_timeout, o_overrun;
  logic [2:0]         o_dbg_state;

  uart_alu_framer #(.NB_DATA(NB_DATA), .NB_CODE(NB_CODE), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_rx_done(i_rx_done), .i_rx_data(i_rx_data),
    .i_tx_done(i_tx_done), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
    .o_result(o_result), .o_result_valid(o_result_valid), .o_error(o_error),
    .o_timeout(o_timeout), .o_overrun(o_overrun), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // scoreboard state
  logic [7:0]  exp_q[$];
  int          rv_cnt = 0, rv_cyc = 0, to_cnt = 0, to_cyc = 0, ovr_cnt = 0, ovr_cyc = 0, txs_cnt = 0;
  logic [15:0] rv_res = '0;
  logic        rv_err = 1'b0;
  logic        resp_busy = 1'b0;

  // Output monitor: records strobes and checks every transmitted byte against exp_q.
  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge i_clk);
      if (o_result_valid) begin rv_cnt++; rv_cyc = cyc; rv_res = o_result; rv_err = o_error; end
      if (o_timeout) begin to_cnt++; to_cyc = cyc; end
      if (o_overrun) begin ovr_cnt++; ovr_cyc = cyc; end
      if (o_tx_start) begin
        txs_cnt++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL tx_unexpected: o_tx_start with byte %02h, expected no transmission", o_tx_data);
        end else begin
          e = exp_q.pop_front();
          if (o_tx_data !== e) begin
            fails++;
            $display("FAIL tx_byte: got %02h, expected %02h", o_tx_data, e);
          end
        end
      end
    end
  end

  // Transmitter model: answers each o_tx_start with i_tx_done after a random delay.
  initial begin : responder
    logic [7:0] held;
    int         n;
    logic       abort;
    forever begin
      @(negedge i_clk);
      if (o_tx_start && !i_reset) begin
        resp_busy = 1'b1;
        held = o_tx_data;
        n = $urandom_range(1, 4);
        abort = 1'b0;
        for (int k = 0; k < n; k++) begin
          @(negedge i_clk);
          if (i_reset) abort = 1'b1;
          if (!abort) begin
            tests++;
            if (o_tx_data !== held) begin
              fails++;
              $display("FAIL tx_hold: o_tx_data %02h, expected held %02h", o_tx_data, held);
            end
          end
        end
        if (!abort) begin
          i_tx_done = 1'b1;
          @(negedge i_clk);
          i_tx_done = 1'b0;
        end
        resp_busy = 1'b0;
      end
    end
  end

  // Reference ALU written from the opcode table with plain integer arithmetic.
  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [7:0] opb, output logic bad);
    longint r;
    bad = 1'b0;
    r = 0;
    case (opb[5:0])
      6'h20: r = longint'(a) + longint'(b);
      6'h22: r = longint'(a) - longint'(b) + 65536;
      6'h24: r = longint'(a & b);
      6'h25: r = longint'(a | b);
      6'h26: r = longint'(a ^ b);
      6'h27: r = 65535 - longint'(a | b);
      6'h03: begin
        if (b >= 16) r = a[15] ? 65535 : 0;
        else begin
          r = a;
          for (int i = 0; i < int'(b); i++) r = (r >> 1) + (a[15] ? 32768 : 0);
        end
      end
      6'h02: r = (b >= 16) ? 0 : longint'(a) / (longint'(1) << b);
      default: begin bad = 1'b1; r = 0; end
    endcase
    return r[15:0];
  endfunction

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, output int s);
    @(negedge i_clk);
    i_rx_done = 1'b1;
    i_rx_data = b;
    s = cyc;
    @(negedge i_clk);
    i_rx_done = 1'b0;
    i_rx_data = 8'($urandom);
  endtask

  task automatic send_operands(input logic [15:0] a, input logic [15:0] b);
    int s;
    send_byte(a[7:0], s);
    send_byte(a[15:8], s);
    send_byte(b[7:0], s);
    send_byte(b[15:8], s);
  endtask

  task automatic do_reset();
    #1 i_reset = 1'b1;
    @(negedge i_clk);
    tests++;
    if ({o_tx_start, o_result_valid, o_error, o_timeout, o_overrun} !== 5'b0 ||
        o_result !== 16'h0 || o_tx_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_outputs: strobes %b result %04h tx_data %02h, expected all zero",
               {o_tx_start, o_result_valid, o_error, o_timeout, o_overrun}, o_result, o_tx_data);
    end
    tick(2);
    i_reset = 1'b0;
    exp_q.delete();
  endtask

  // One full frame with result, latency, error and TX-sequence checks.
  task automatic run_frame(input logic [15:0] a, input logic [15:0] b, input logic [7:0] opb,
                           input logic inject_ovr);
    int s, s2, t, rv0, ovr0, tx0, ntx;
    logic bad;
    logic [15:0] exp;
    exp = model(a, b, opb, bad);
    ntx = bad ? 1 : 2;
    if (bad) exp_q.push_back(8'hEE);
    else begin exp_q.push_back(exp[7:0]); exp_q.push_back(exp[15:8]); end
    rv0 = rv_cnt; ovr0 = ovr_cnt; tx0 = txs_cnt;
    send_operands(a, b);
    send_byte(opb, s);
    t = 0;
    while (rv_cnt == rv0 && t < 10) begin tick(1); t++; end
    tests++;
    if (rv_cnt == rv0) begin
      fails++;
      $display("FAIL result_valid_missing: no o_result_valid within 10 cycles (op %02h)", opb);
    end else begin
      if (rv_cyc !== s + 1) begin
        fails++;
        $display("FAIL result_latency: valid %0d cycles after opcode strobe, expected 1", rv_cyc - s);
      end
      tests++;
      if (rv_res !== exp) begin
        fails++;
        $display("FAIL result_value: a=%04h b=%04h op=%02h got %04h expected %04h", a, b, opb, rv_res, exp);
      end
      tests++;
      if (rv_err !== bad) begin
        fails++;
        $display("FAIL error_flag: op=%02h o_error %b expected %b", opb, rv_err, bad);
      end
    end
    if (inject_ovr) begin
      t = 0;
      while (txs_cnt == tx0 && t < 20) begin tick(1); t++; end
      send_byte(8'($urandom), s2);
      tick(2);
      tests++;
      if (ovr_cnt !== ovr0 + 1 || ovr_cyc !== s2 + 1) begin
        fails++;
        $display("FAIL overrun: pulses %0d at +%0d cycles, expected 1 at +1", ovr_cnt - ovr0, ovr_cyc - s2);
      end
    end
    t = 0;
    while ((exp_q.size() != 0 || resp_busy) && t < 300) begin tick(1); t++; end
    tick(2);
    tests++;
    if (txs_cnt - tx0 !== ntx) begin
      fails++;
      $display("FAIL tx_count: op=%02h sent %0d bytes, expected %0d", opb, txs_cnt - tx0, ntx);
    end
  endtask

  // scenario tasks
  task automatic test_reset();
    tick(1);
    tests++;
    if ({o_tx_start, o_result_valid, o_error, o_timeout, o_overrun} !== 5'b0) begin
      fails++;
      $display("FAIL reset_strobes: %b expected 00000", {o_tx_start, o_result_valid, o_error, o_timeout, o_overrun});
    end
    tests++;
    if (o_result !== 16'h0) begin fails++; $display("FAIL reset_result: got %04h expected 0000", o_result); end
    tests++;
    if (o_tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data: got %02h expected 00", o_tx_data); end
    i_reset = 1'b0;
    tick(3);
    tests++;
    if (txs_cnt !== 0 || rv_cnt !== 0) begin
      fails++;
      $display("FAIL reset_idle: %0d tx starts %0d results after reset, expected 0", txs_cnt, rv_cnt);
    end
  endtask

  task automatic test_vectors();
    run_frame(16'h1234, 16'h0001, 8'h20, 1'b0);
    run_frame(16'hFFFF, 16'h0001, 8'h20, 1'b0);
    run_frame(16'h8000, 16'h0004, 8'h03, 1'b0);
    run_frame(16'h8000, 16'h0004, 8'h02, 1'b0);
    run_frame(16'h1234, 16'h5678, 8'h3F, 1'b0);
    run_frame(16'h8001, 16'h0010, 8'h03, 1'b0);
    run_frame(16'h8001, 16'h0010, 8'h02, 1'b0);
    run_frame(16'h7FFF, 16'h0020, 8'h03, 1'b0);
    run_frame(16'h8000, 16'h000F, 8'h03, 1'b0);
    run_frame(16'h0003, 16'h0005, 8'h22, 1'b0);
  endtask

  task automatic test_random(input int n);
    logic [7:0] ops[8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};
    logic [7:0] opb;
    logic [15:0] a, b;
    for (int i = 0; i < n; i++) begin
      a = 16'($urandom);
      b = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      if ($urandom_range(0, 5) == 0) opb = 8'($urandom);
      else opb = {2'($urandom), ops[$urandom_range(0, 7)][5:0]};
      run_frame(a, b, opb, 1'b0);
    end
  endtask

  task automatic test_overrun();
    run_frame(16'hA5C3, 16'h0F0F, 8'h26, 1'b1);
    run_frame(16'h0102, 16'h0304, 8'h20, 1'b0);
  endtask

  task automatic test_timeout();
    int s, t, to0, rv0;
    logic [15:0] r0;
    r0 = o_result; to0 = to_cnt; rv0 = rv_cnt;
    send_byte(8'h11, s);
    send_byte(8'h22, s);
    t = 0;
    while (to_cnt == to0 && t < 100) begin tick(1); t++; end
    tests++;
    if (to_cnt !== to0 + 1 || to_cyc !== s + 1 + TIMEOUT_CYC) begin
      fails++;
      $display("FAIL timeout_pulse: %0d pulses at +%0d cycles, expected 1 at +%0d",
               to_cnt - to0, to_cyc - s, 1 + TIMEOUT_CYC);
    end
    tests++;
    if (o_result !== r0 || rv_cnt !== rv0) begin
      fails++;
      $display("FAIL timeout_result: o_result %04h (%0d results), expected %04h unchanged", o_result, rv_cnt - rv0, r0);
    end
    run_frame(16'h0F00, 16'h00F0, 8'h25, 1'b0);
  endtask

  task automatic test_timeout_collision();
    int s, t, to0;
    to0 = to_cnt;
    send_byte(8'h77, s);
    while (cyc < s + TIMEOUT_CYC) tick(1);
    i_rx_done = 1'b1;
    i_rx_data = 8'h99;
    tick(1);
    i_rx_done = 1'b0;
    t = 0;
    while (to_cnt == to0 && t < 10) begin tick(1); t++; end
    tests++;
    if (to_cnt !== to0 + 1 || to_cyc !== s + 1 + TIMEOUT_CYC) begin
      fails++;
      $display("FAIL timeout_collision: %0d pulses at +%0d cycles, expected 1 at +%0d",
               to_cnt - to0, to_cyc - s, 1 + TIMEOUT_CYC);
    end
    run_frame(16'h4321, 16'h1111, 8'h22, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    int s, tx0;
    send_byte(8'h01, s);
    send_byte(8'h02, s);
    send_byte(8'h03, s);
    do_reset();
    tx0 = txs_cnt;
    tick(20);
    tests++;
    if (txs_cnt !== tx0) begin fails++; $display("FAIL reset_frame_tx: %0d tx starts, expected 0", txs_cnt - tx0); end
    run_frame(16'h00FF, 16'h0F0F, 8'h24, 1'b0);
  endtask

  task automatic test_reset_mid_tx();
    int s, t, tx0;
    logic bad;
    logic [15:0] exp;
    exp = model(16'hBEEF, 16'h1111, 8'h20, bad);
    exp_q.push_back(exp[7:0]);
    exp_q.push_back(exp[15:8]);
    tx0 = txs_cnt;
    send_operands(16'hBEEF, 16'h1111);
    send_byte(8'h20, s);
    t = 0;
    while (!o_tx_start && t < 20) begin @(negedge i_clk); t++; end
    do_reset();
    tx0 = txs_cnt;
    tick(30);
    tests++;
    if (txs_cnt !== tx0) begin fails++; $display("FAIL reset_tx_resume: %0d tx starts, expected 0", txs_cnt - tx0); end
    run_frame(16'h2222, 16'h3333, 8'h27, 1'b0);
  endtask

  task automatic test_idle_no_timeout();
    int to0;
    to0 = to_cnt;
    tick(3 * TIMEOUT_CYC);
    tests++;
    if (to_cnt !== to0) begin fails++; $display("FAIL idle_timeout: %0d pulses while idle, expected 0", to_cnt - to0); end
  endtask

  initial begin : watchdog
    #3_000_000;
    fails++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_vectors();
    test_random(24);
    test_overrun();
    test_timeout();
    test_timeout_collision();
    test_reset_mid_frame();
    test_reset_mid_tx();
    test_idle_no_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
